// File: rtl/mac_sequencer.sv
// Dot-product sequencer for the MAC datapath: walks the shared operand SRAM address,
// drives MAC clear/enable and captures the final accumulator value.
module mac_sequencer #(
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MAC_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   len,
  input  logic              step_mode,
  input  logic              step,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_cs_n,
  output logic              sram_oe_n,
  output logic              mac_clr,
  output logic              mac_en,
  input  logic [DATA_W-1:0] mac_result,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam int unsigned LEN_W    = ADDR_W + 1;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned LAT_LAST = (MAC_LAT > 0) ? MAC_LAT - 1 : 0;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [ADDR_W-1:0]   last_q;
  logic                step_mode_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   result_q;
  logic                valid_q;
  logic [LEN_W-1:0]    len_clamped;
  logic                advance;

  assign len_clamped = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
  // In step mode a term is consumed only on a step pulse; free mode consumes one per cycle.
  assign advance     = step_mode_q ? step : 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      step_mode_q <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
    end else if (abort) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            step_mode_q <= step_mode;
            last_q      <= ADDR_W'(len_clamped - LEN_W'(1));
            idx_q       <= '0;
            if (len_clamped == '0) begin
              result_q <= '0;
              valid_q  <= 1'b1;
              state_q  <= DONE;
            end else begin
              valid_q <= 1'b0;
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (advance) begin
            if (idx_q == last_q) begin
              idx_q <= '0;
              cnt_q <= '0;
              if (MAC_LAT > 0) begin
                state_q <= DRAIN;
              end else begin
                result_q <= mac_result;
                valid_q  <= 1'b1;
                state_q  <= DONE;
              end
            end else begin
              idx_q <= idx_q + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          // Wait out the MAC pipeline before sampling the accumulator.
          if (cnt_q == CNT_W'(LAT_LAST)) begin
            result_q <= mac_result;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; reset therefore deselects the SRAMs immediately.
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign mac_clr      = (state_q == IDLE);
  assign sram_cs_n    = (state_q != ISSUE);
  assign sram_oe_n    = (state_q != ISSUE);
  assign sram_addr    = (state_q == ISSUE) ? idx_q : '0;
  assign mac_en       = (state_q == ISSUE) && (step_mode_q ? (step && !abort) : 1'b1);
  assign result       = result_q;
  assign result_valid = valid_q;

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Controller that sequences the MAC datapath through a dot product of operand pairs held in the two operand SRAMs (A and B).
- Drives the shared SRAM address, chip-select and output-enable. Drives MAC clear and enable. Captures the final accumulator value into a result register.
- Replaces ad-hoc top-level FSM sequencing of the RESULT phase.
- Supports free-running and single-step (button-driven) operation, plus abort.

Parameters:
- ADDR_W, 3, SRAM address width; depth = 2**ADDR_W (8).
- DATA_W, 16, MAC operand/result width.
- MAC_LAT, 1, cycles from last mac_en to accumulator valid; 0..7 legal.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to begin a sequence; sampled in IDLE only.
- abort  in  1  synchronous; return to IDLE from any state.
- len  in  ADDR_W+1  number of terms N; values > 2**ADDR_W are clamped to 2**ADDR_W.
- step_mode  in  1  1 = advance one term per step pulse; sampled at start.
- step  in  1  single-cycle pulse, already debounced and synchronised.
- sram_addr  out  ADDR_W  shared address to SRAM A and SRAM B.
- sram_cs_n  out  1  chip select, active-low, common to both SRAMs.
- sram_oe_n  out  1  output enable, active-low, common to both SRAMs.
- mac_clr  out  1  active-high MAC accumulator clear.
- mac_en  out  1  accumulate the operands present this cycle.
- mac_result  in  DATA_W  MAC accumulator value.
- result  out  DATA_W  captured sum.
- result_valid  out  1  result holds a completed sequence.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values:
  - state = IDLE, idx = 0, sram_addr = 0.
  - sram_cs_n = 1, sram_oe_n = 1, mac_clr = 1, mac_en = 0.
  - result = 0, result_valid = 0, busy = 0, done = 0.
- Outputs are decoded from registered state and idx; no combinational path from inputs to outputs, except mac_en from step in step mode.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - mac_clr = 1, cs_n = oe_n = 1.
  - On start & !abort: latch clamped N and step_mode; clear result_valid.
  - N = 0: go to DONE with result loaded as 0, no SRAM access.
  - N ≥ 1: go to ISSUE with idx = 0.
- ISSUE:
  - mac_clr = 0, cs_n = 0, oe_n = 0, sram_addr = idx.
  - Free mode: mac_en = 1 every cycle; idx increments each cycle.
  - Step mode: mac_en = step. idx increments only on a cycle with step = 1. Address and cs_n/oe_n are held between steps.
  - After the term with idx = N-1 is accumulated:
    - MAC_LAT > 0: go to DRAIN.
    - MAC_LAT = 0: go to DONE.
  - idx does not wrap; the sequence always ends at N-1.
- DRAIN:
  - cs_n = oe_n = 1, mac_en = 0, mac_clr = 0.
  - Lasts exactly MAC_LAT cycles, then DONE.
  - step is ignored.
- Result capture: result <= mac_result on the clock edge entering DONE.
- DONE (one cycle):
  - done = 1, result_valid = 1, mac_clr = 0.
  - Next state is IDLE.
  - result and result_valid hold until the next accepted start, abort, or reset.
- Latency (free mode), start sampled at cycle 0:
  - ISSUE cycles 1..N.
  - DRAIN cycles N+1..N+MAC_LAT.
  - done high in cycle N+1+MAC_LAT.
- Abort:
  - From any state: IDLE next cycle, result_valid = 0, no done pulse.
  - mac_clr = 1 from the next cycle.
  - abort wins over start and over step in the same cycle.
- start while busy: ignored, no queuing.
- len and step_mode changes while busy: ignored (values latched at start).
- rst asserted mid-sequence: immediate return to reset values; SRAMs deselected asynchronously.

Test Plan:
- Free mode, behavioural integer MAC stub with MAC_LAT = 1. SRAM A = 1..8, B = all 1, N = 8, start at cycle 0 → addr 0..7 on cycles 1..8; done at cycle 10; result = 0x0024; result_valid = 1.
- Step mode, same data, N = 3, step pulses at cycles 5, 9, 20 → addr holds 0 until the step at cycle 5; exactly 3 mac_en pulses; done 2 cycles after the last step; result = 0x0006.
- N = 0 → done at cycle 1; result = 0; sram_cs_n stays 1 throughout.
- len = 15 → clamped to 8; last addr = 7; no wrap to 0; result as in the first scenario.
- abort at cycle 4 of an N = 8 run → IDLE at cycle 5; mac_clr = 1; no done; result_valid = 0. A later start completes normally.
- start held high at cycles 0..12 → second run begins only after IDLE is re-entered; busy drops for exactly one cycle between runs.
- rst pulse mid-ISSUE → outputs return to reset values without waiting for a clk edge.
